// File: rtl/fifo_wr_arb.sv
// fifo_wr_arb: round-robin arbiter sharing one FIFO write port among
// NUM_REQ producers. Ownership is granted in bursts of up to BURST_LEN words,
// and the FIFO write enable/data are registered.
//
// Requester handshake (valid/ready):
//   req[i] is "valid": the word on req_data[i] is presented and must stay
//   stable while req[i] is high and ack[i] is low. ack[i] is "ready": it is
//   combinational and one-hot. A word is transferred on every cycle where
//   req[i] && ack[i]. The requester then presents its next word after that
//   edge. ack is never raised while the FIFO cannot accept a write.
module fifo_wr_arb #(
   parameter int NUM_REQ   = 4,
   parameter int DATA_W    = 8,
   parameter int BURST_LEN = 16
) (
   input  logic                       wr_clk,
   input  logic                       rst_n,
   input  logic [NUM_REQ-1:0]         req,
   input  logic [NUM_REQ*DATA_W-1:0]  req_data,
   output logic [NUM_REQ-1:0]         ack,
   input  logic                       wr_rst_busy,
   input  logic                       almost_full,
   input  logic                       full,
   output logic                       fifo_wr_en,
   output logic [DATA_W-1:0]          fifo_wr_data,
   output logic [$clog2(NUM_REQ)-1:0] grant_id,
   output logic                       busy
);

   localparam int GW = $clog2(NUM_REQ);
   localparam int CW = $clog2(BURST_LEN + 1);
   localparam logic [CW-1:0] BURST_MAX = CW'(BURST_LEN);
   localparam logic [GW-1:0] LAST_ID   = GW'(NUM_REQ - 1);
   localparam logic [GW:0]   NUM_REQ_W = (GW + 1)'(NUM_REQ);

   localparam logic [0:0] IDLE  = 1'b0;
   localparam logic [0:0] BURST = 1'b1;

   logic [0:0]        state;
   logic [GW-1:0]     rr_ptr;
   logic [CW-1:0]     cnt;
   logic [CW-1:0]     cnt_inc;
   logic              ok;
   logic              ack_any;
   logic              burst_end;
   logic              found;
   logic [GW-1:0]     winner;
   logic [GW:0]       probe;
   logic [GW-1:0]     next_ptr;
   logic [DATA_W-1:0] sel_data;

   // The FIFO can take a write only when it is out of reset and has room.
   assign ok       = !wr_rst_busy && !almost_full && !full;
   assign ack_any  = (state == BURST) && req[grant_id] && ok && (cnt < BURST_MAX);
   assign cnt_inc  = cnt + CW'(1);
   // A burst ends on its last allowed word, when the owner stops requesting,
   // or as soon as the FIFO signals it is filling up.
   assign burst_end = (ack_any && (cnt_inc == BURST_MAX)) || !req[grant_id]
                      || almost_full || full;
   assign next_ptr = (grant_id == LAST_ID) ? '0 : grant_id + GW'(1);
   assign sel_data = req_data[int'(grant_id) * DATA_W +: DATA_W];
   // busy doubles as the visible FSM state.
   assign busy     = (state == BURST);

   // Pick the first active requester at or after rr_ptr, wrapping around.
   always_comb begin
      found  = 1'b0;
      winner = '0;
      probe  = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         probe = {1'b0, rr_ptr} + (GW + 1)'(i);
         if (probe >= NUM_REQ_W) begin
            probe = probe - NUM_REQ_W;
         end
         if (!found && req[probe[GW-1:0]]) begin
            found  = 1'b1;
            winner = probe[GW-1:0];
         end
      end
   end

   // One-hot accept pulse for the current owner.
   always_comb begin
      ack = '0;
      if (ack_any) begin
         ack[grant_id] = 1'b1;
      end
   end

   // Arbitration FSM, burst counter and registered FIFO write port.
   always_ff @(posedge wr_clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         rr_ptr       <= '0;
         cnt          <= '0;
         grant_id     <= '0;
         fifo_wr_en   <= 1'b0;
         fifo_wr_data <= '0;
      end else if (wr_rst_busy) begin
         // FIFO reset in progress: drop any burst but remember whose turn is next.
         state      <= IDLE;
         fifo_wr_en <= 1'b0;
         cnt        <= '0;
      end else begin
         fifo_wr_en <= ack_any;
         if (ack_any) begin
            fifo_wr_data <= sel_data;
            cnt          <= cnt_inc;
         end
         case (state)
            IDLE: begin
               if (ok && found) begin
                  state    <= BURST;
                  grant_id <= winner;
                  cnt      <= '0;
               end
            end
            BURST: begin
               if (burst_end) begin
                  state  <= IDLE;
                  rr_ptr <= next_ptr;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fifo_wr_arb.sv
// tb_fifo_wr_arb: directed bench for the round-robin FIFO write arbiter.
module tb_fifo_wr_arb;

   localparam int NUM_REQ   = 4;
   localparam int DATA_W    = 8;
   localparam int BURST_LEN = 16;
   localparam int PERIOD    = BURST_LEN + 1;

   logic                       wr_clk;
   logic                       rst_n;
   logic [NUM_REQ-1:0]         req;
   logic [NUM_REQ*DATA_W-1:0]  req_data;
   logic [NUM_REQ-1:0]         ack;
   logic                       wr_rst_busy;
   logic                       almost_full;
   logic                       full;
   logic                       fifo_wr_en;
   logic [DATA_W-1:0]          fifo_wr_data;
   logic [$clog2(NUM_REQ)-1:0] grant_id;
   logic                       busy;

   logic [DATA_W-1:0] wd [NUM_REQ];
   logic [DATA_W-1:0] ew [NUM_REQ];
   int total = 0;
   int bad   = 0;

   fifo_wr_arb #(
      .NUM_REQ(NUM_REQ),
      .DATA_W(DATA_W),
      .BURST_LEN(BURST_LEN)
   ) dut (
      .wr_clk(wr_clk),
      .rst_n(rst_n),
      .req(req),
      .req_data(req_data),
      .ack(ack),
      .wr_rst_busy(wr_rst_busy),
      .almost_full(almost_full),
      .full(full),
      .fifo_wr_en(fifo_wr_en),
      .fifo_wr_data(fifo_wr_data),
      .grant_id(grant_id),
      .busy(busy)
   );

   // Clock generation.
   initial begin
      wr_clk = 1'b0;
      forever #5 wr_clk = ~wr_clk;
   end

   // Requester words packed onto the shared data bus.
   always_comb begin
      req_data = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         req_data[i*DATA_W +: DATA_W] = wd[i];
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock: sample ack mid-cycle, then producers advance after the edge.
   task automatic tick();
      logic [NUM_REQ-1:0] a;
      @(negedge wr_clk);
      a = ack;
      @(posedge wr_clk);
      #1;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (a[i]) wd[i] = wd[i] + 8'd1;
      end
   endtask

   // Continuous-request pattern: arbitration cycle, BURST_LEN acks, repeat.
   task automatic run_bursts(input string tag, input int ncyc, input int first_g,
                             input bit rotate);
      logic              exp_en;
      logic [DATA_W-1:0] exp_dat;
      int b, p, g;
      exp_en  = 1'b0;
      exp_dat = '0;
      for (int k = 0; k < ncyc; k++) begin
         b = k / PERIOD;
         p = k % PERIOD;
         g = rotate ? (first_g + b) % NUM_REQ : first_g;
         chk({tag, "_ack"}, 32'(ack), (p == 0) ? 32'd0 : (32'd1 << g));
         chk({tag, "_busy"}, 32'(busy), 32'(p != 0));
         if (p != 0) chk({tag, "_gid"}, 32'(grant_id), 32'(g));
         chk({tag, "_wr_en"}, 32'(fifo_wr_en), 32'(exp_en));
         if (exp_en) chk({tag, "_data"}, 32'(fifo_wr_data), 32'(exp_dat));
         exp_en = (p != 0);
         if (p != 0) begin
            exp_dat = ew[g];
            ew[g]   = ew[g] + 8'd1;
         end
         tick();
      end
   endtask

   initial begin
      // Reset with the FIFO still busy resetting, requester 2 waiting.
      rst_n       = 1'b0;
      wr_rst_busy = 1'b1;
      almost_full = 1'b0;
      full        = 1'b0;
      req         = 4'b0100;
      for (int i = 0; i < NUM_REQ; i++) wd[i] = '0;
      wd[2] = 8'hA0;
      @(posedge wr_clk);
      @(posedge wr_clk);
      #1;
      chk("rst_wr_en", 32'(fifo_wr_en), 32'd0);
      chk("rst_data", 32'(fifo_wr_data), 32'd0);
      chk("rst_gid", 32'(grant_id), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_ack", 32'(ack), 32'd0);

      // wr_rst_busy holds off all writes.
      rst_n = 1'b1;
      for (int c = 0; c < 3; c++) begin
         tick();
         chk("wrb_wr_en", 32'(fifo_wr_en), 32'd0);
         chk("wrb_busy", 32'(busy), 32'd0);
         chk("wrb_ack", 32'(ack), 32'd0);
      end
      wr_rst_busy = 1'b0;
      #1;
      chk("wrb_arb_ack", 32'(ack), 32'd0);
      chk("wrb_arb_en", 32'(fifo_wr_en), 32'd0);
      tick();
      chk("wrb_b1_busy", 32'(busy), 32'd1);
      chk("wrb_b1_gid", 32'(grant_id), 32'd2);
      chk("wrb_b1_ack", 32'(ack), 32'b0100);
      chk("wrb_b1_en", 32'(fifo_wr_en), 32'd0);
      tick();
      chk("wrb_w_en", 32'(fifo_wr_en), 32'd1);
      chk("wrb_w_data", 32'(fifo_wr_data), 32'hA0);
      req = '0;
      #1;
      chk("wrb_drop_ack", 32'(ack), 32'd0);
      tick();
      chk("wrb_end_busy", 32'(busy), 32'd0);
      chk("wrb_end_en", 32'(fifo_wr_en), 32'd0);
      chk("wrb_end_data", 32'(fifo_wr_data), 32'hA0);
      tick();

      // Single requester 0 streaming words 0,1,2...
      wd[0] = 8'd0;
      ew[0] = 8'd0;
      req   = 4'b0001;
      #1;
      run_bursts("single", 36, 0, 1'b0);

      // Asynchronous reset in the middle of a burst.
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_wr_en", 32'(fifo_wr_en), 32'd0);
      chk("arst_data", 32'(fifo_wr_data), 32'd0);
      chk("arst_busy", 32'(busy), 32'd0);
      chk("arst_gid", 32'(grant_id), 32'd0);
      chk("arst_ack", 32'(ack), 32'd0);

      // All four requesting: grants must rotate 0,1,2,3,0 from a fresh pointer.
      req = 4'b1111;
      for (int i = 0; i < NUM_REQ; i++) begin
         wd[i] = 8'(i * 8'h40);
         ew[i] = 8'(i * 8'h40);
      end
      @(posedge wr_clk);
      #1;
      rst_n = 1'b1;
      #1;
      run_bursts("rr", 5 * PERIOD, 0, 1'b1);
      req = '0;
      #1;
      tick();

      // Requester 1 stops after 3 words while requester 3 waits.
      wd[1] = 8'h30;
      wd[3] = 8'h70;
      req   = 4'b1010;
      #1;
      chk("drop_k0_ack", 32'(ack), 32'd0);
      chk("drop_k0_busy", 32'(busy), 32'd0);
      tick();
      chk("drop_k1_busy", 32'(busy), 32'd1);
      chk("drop_k1_gid", 32'(grant_id), 32'd1);
      chk("drop_k1_ack", 32'(ack), 32'b0010);
      chk("drop_k1_en", 32'(fifo_wr_en), 32'd0);
      tick();
      chk("drop_k2_ack", 32'(ack), 32'b0010);
      chk("drop_k2_en", 32'(fifo_wr_en), 32'd1);
      chk("drop_k2_data", 32'(fifo_wr_data), 32'h30);
      tick();
      chk("drop_k3_ack", 32'(ack), 32'b0010);
      chk("drop_k3_data", 32'(fifo_wr_data), 32'h31);
      tick();
      req = 4'b1000;
      #1;
      chk("drop_k4_ack", 32'(ack), 32'd0);
      chk("drop_k4_busy", 32'(busy), 32'd1);
      chk("drop_k4_en", 32'(fifo_wr_en), 32'd1);
      chk("drop_k4_data", 32'(fifo_wr_data), 32'h32);
      tick();
      chk("drop_k5_busy", 32'(busy), 32'd0);
      chk("drop_k5_en", 32'(fifo_wr_en), 32'd0);
      chk("drop_k5_ack", 32'(ack), 32'd0);
      chk("drop_k5_data", 32'(fifo_wr_data), 32'h32);
      tick();
      chk("drop_k6_busy", 32'(busy), 32'd1);
      chk("drop_k6_gid", 32'(grant_id), 32'd3);
      chk("drop_k6_ack", 32'(ack), 32'b1000);
      tick();
      chk("drop_k7_en", 32'(fifo_wr_en), 32'd1);
      chk("drop_k7_data", 32'(fifo_wr_data), 32'h70);
      req = '0;
      #1;
      tick();
      tick();

      // almost_full after the 5th word, then full suppressing ack.
      wd[1] = 8'h50;
      wd[2] = 8'h90;
      req   = 4'b0110;
      #1;
      chk("af_k0_ack", 32'(ack), 32'd0);
      tick();
      for (int c = 0; c < 5; c++) begin
         chk("af_burst_ack", 32'(ack), 32'b0010);
         chk("af_burst_gid", 32'(grant_id), 32'd1);
         tick();
      end
      almost_full = 1'b1;
      #1;
      chk("af_k6_ack", 32'(ack), 32'd0);
      chk("af_k6_busy", 32'(busy), 32'd1);
      chk("af_k6_en", 32'(fifo_wr_en), 32'd1);
      chk("af_k6_data", 32'(fifo_wr_data), 32'h54);
      tick();
      chk("af_k7_busy", 32'(busy), 32'd0);
      chk("af_k7_en", 32'(fifo_wr_en), 32'd0);
      chk("af_k7_ack", 32'(ack), 32'd0);
      tick();
      chk("af_k8_busy", 32'(busy), 32'd0);
      almost_full = 1'b0;
      #1;
      chk("af_k8_ack", 32'(ack), 32'd0);
      tick();
      chk("af_k9_busy", 32'(busy), 32'd1);
      chk("af_k9_gid", 32'(grant_id), 32'd2);
      chk("af_k9_ack", 32'(ack), 32'b0100);
      tick();
      chk("af_k10_en", 32'(fifo_wr_en), 32'd1);
      chk("af_k10_data", 32'(fifo_wr_data), 32'h90);
      full = 1'b1;
      #1;
      chk("full_ack", 32'(ack), 32'd0);
      tick();
      chk("full_busy", 32'(busy), 32'd0);
      chk("full_en", 32'(fifo_wr_en), 32'd0);
      chk("full_data", 32'(fifo_wr_data), 32'h90);
      full = 1'b0;
      req  = '0;
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
